// File: rtl/ofm_requant_pack.sv
// ofm_requant_pack: requantizes per-column conv sums, packs COL lanes into one word, FIFO-buffers them to the OFM writer.
// Optional ReLU clamp is built only when the OFM_REQUANT_RELU_EN macro is defined.
module ofm_requant_pack #(
    parameter int COL         = 8,
    parameter int OFM_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int WCNT_WIDTH  = 12,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_conv,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic                          cfg_relu,
    input  logic [WCNT_WIDTH-1:0]         cfg_words,
    input  logic [COL-1:0]                sum_valid,
    input  logic signed [OFM_WIDTH-1:0]   sum [COL],
    input  logic                          ofm_ready,
    output logic                          ofm_valid,
    output logic [COL*OUT_WIDTH-1:0]      ofm_data,
    output logic                          ofm_last,
    output logic                          wb_done,
    output logic                          err_overrun,
    output logic                          err_fifo_ovf,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = COL * OUT_WIDTH;
    localparam logic signed [OFM_WIDTH:0] SAT_MAX = (OFM_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [OFM_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic [SHIFT_WIDTH-1:0]      shift_r;
    logic [WCNT_WIDTH-1:0]       words_r;
    logic                        relu_on;

    logic signed [OFM_WIDTH:0]   rnd;
    logic signed [OFM_WIDTH:0]   acc     [COL];
    logic signed [OFM_WIDTH:0]   shifted [COL];
    logic [OUT_WIDTH-1:0]        q_next  [COL];
    logic [OUT_WIDTH-1:0]        q       [COL];
    logic [COL-1:0]              qv;

    logic [OUT_WIDTH-1:0]        hold    [COL];
    logic [COL-1:0]              full;
    logic                        complete;
    logic [DW-1:0]               packed_word;
    logic                        word_last;
    logic [WCNT_WIDTH-1:0]       wcnt;

    logic [DW:0]                 mem [FIFO_DEPTH];
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        pop;
    logic                        push_ok;
    logic [DW:0]                 head;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= '0;
            words_r <= '0;
        end else if (start_conv) begin
            shift_r <= cfg_shift;
            words_r <= cfg_words;
        end
    end

`ifdef OFM_REQUANT_RELU_EN
    logic relu_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            relu_r <= 1'b0;
        end else if (start_conv) begin
            relu_r <= cfg_relu;
        end
    end

    assign relu_on = relu_r;
`else
    logic unused_cfg_relu;

    assign unused_cfg_relu = cfg_relu;
    assign relu_on         = 1'b0;
`endif

    // Round half toward +inf: add half an LSB of the shifted result before the arithmetic shift.
    assign rnd = (shift_r == '0) ? '0 : ((OFM_WIDTH+1)'(1) << (shift_r - SHIFT_WIDTH'(1)));

    always_comb begin
        for (int i = 0; i < COL; i++) begin
            acc[i]     = $signed({sum[i][OFM_WIDTH-1], sum[i]}) + rnd;
            shifted[i] = acc[i] >>> shift_r;
            if (relu_on && shifted[i][OFM_WIDTH]) begin
                shifted[i] = '0;
            end
            if (shifted[i] > SAT_MAX) begin
                q_next[i] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shifted[i] < SAT_MIN) begin
                q_next[i] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                q_next[i] = shifted[i][OUT_WIDTH-1:0];
            end
        end
    end

    // Strobes in the start_conv cycle are dropped so a new conv never inherits stale sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            qv <= '0;
            for (int i = 0; i < COL; i++) begin
                q[i] <= '0;
            end
        end else begin
            qv <= start_conv ? '0 : sum_valid;
            for (int i = 0; i < COL; i++) begin
                q[i] <= q_next[i];
            end
        end
    end

    assign complete  = &(full | qv);
    assign word_last = (wcnt == (words_r - WCNT_WIDTH'(1)));

    always_comb begin
        packed_word = '0;
        for (int i = 0; i < COL; i++) begin
            packed_word[i*OUT_WIDTH +: OUT_WIDTH] = qv[i] ? q[i] : hold[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < COL; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < COL; i++) begin
                if (qv[i]) begin
                    hold[i] <= q[i];
                end
            end
        end
    end

    // A lane strobed while its previous value is still waiting is an overrun; the newer value wins.
    always_ff @(posedge clk) begin
        if (rst || start_conv) begin
            full        <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (complete) begin
                full <= '0;
            end else begin
                full <= full | qv;
                if (|(qv & full)) begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = ofm_valid && ofm_ready;
    assign push_ok    = complete && (!fifo_full || pop);
    assign head       = mem[rd_ptr[AW-1:0]];

    // The word counter advances even for dropped words so ofm_last stays aligned with the conv.
    always_ff @(posedge clk) begin
        if (rst || start_conv) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wcnt         <= '0;
            err_fifo_ovf <= 1'b0;
        end else begin
            if (complete) begin
                wcnt <= word_last ? '0 : wcnt + WCNT_WIDTH'(1);
                if (push_ok) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end else begin
                    err_fifo_ovf <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {word_last, packed_word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_done <= 1'b0;
        end else begin
            wb_done <= pop && head[DW];
        end
    end

    assign ofm_valid = !fifo_empty;
    assign ofm_data  = fifo_empty ? '0 : head[DW-1:0];
    assign ofm_last  = !fifo_empty && head[DW];
    assign busy      = (|full) || (|qv) || !fifo_empty;

endmodule

// File: tb/tb_ofm_requant_pack.sv
// Directed testbench for ofm_requant_pack: requant math, lane assembly, overrun, FIFO backpressure, word wrap.
module tb_ofm_requant_pack;

    localparam int COL = 8;
    localparam int OW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_conv;
    logic [4:0]        cfg_shift;
    logic              cfg_relu;
    logic [11:0]       cfg_words;
    logic [COL-1:0]    sum_valid;
    logic signed [31:0] sum [COL];
    logic              ofm_ready;
    logic              ofm_valid;
    logic [COL*OW-1:0] ofm_data;
    logic              ofm_last;
    logic              wb_done;
    logic              err_overrun;
    logic              err_fifo_ovf;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic signed [31:0] test_sums [COL];
    logic [63:0]        exp_data;
    logic [7:0]         lane_val;

    ofm_requant_pack dut (
        .clk          (clk),
        .rst          (rst),
        .start_conv   (start_conv),
        .cfg_shift    (cfg_shift),
        .cfg_relu     (cfg_relu),
        .cfg_words    (cfg_words),
        .sum_valid    (sum_valid),
        .sum          (sum),
        .ofm_ready    (ofm_ready),
        .ofm_valid    (ofm_valid),
        .ofm_data     (ofm_data),
        .ofm_last     (ofm_last),
        .wb_done      (wb_done),
        .err_overrun  (err_overrun),
        .err_fifo_ovf (err_fifo_ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] sh, input logic relu, input logic [11:0] words);
        cfg_shift  = sh;
        cfg_relu   = relu;
        cfg_words  = words;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
    endtask

    task automatic strobe_all(input logic signed [31:0] v);
        for (int i = 0; i < COL; i++) sum[i] = v;
        sum_valid = '1;
        tick();
        sum_valid = '0;
    endtask

    task automatic load_basic_sums;
        test_sums[0] = 0;     test_sums[1] = 8;     test_sums[2] = 24;    test_sums[3] = -8;
        test_sums[4] = -24;   test_sums[5] = 4095;  test_sums[6] = -4096; test_sums[7] = 7;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (ofm_valid !== 1'b0)    begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", ofm_valid); end
        total++; if (ofm_data !== 64'h0)    begin bad++; $display("[TB] FAIL reset_data: got %h want 0", ofm_data); end
        total++; if (ofm_last !== 1'b0)     begin bad++; $display("[TB] FAIL reset_last: got %b want 0", ofm_last); end
        total++; if (wb_done !== 1'b0)      begin bad++; $display("[TB] FAIL reset_wb_done: got %b want 0", wb_done); end
        total++; if (err_overrun !== 1'b0)  begin bad++; $display("[TB] FAIL reset_overrun: got %b want 0", err_overrun); end
        total++; if (err_fifo_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_fifo_ovf: got %b want 0", err_fifo_ovf); end
        total++; if (busy !== 1'b0)         begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_requant;
        $display("[TB] basic requant");
        do_start(5'd4, 1'b0, 12'd1);
        load_basic_sums();
        for (int i = 0; i < COL; i++) sum[i] = test_sums[i];
        sum_valid = '1;
        tick();
        sum_valid = '0;
        total++; if (ofm_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_t1: got %b want 0", ofm_valid); end
        tick();
        total++; if (ofm_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid_t2: got %b want 1", ofm_valid); end
        total++; if (ofm_data !== 64'h00807fff00020100) begin bad++; $display("[TB] FAIL basic_data: got %h want %h", ofm_data, 64'h00807fff00020100); end
        total++; if (ofm_last !== 1'b1) begin bad++; $display("[TB] FAIL basic_last: got %b want 1", ofm_last); end
        ofm_ready = 1'b1;
        tick();
        ofm_ready = 1'b0;
        total++; if (wb_done !== 1'b1)   begin bad++; $display("[TB] FAIL basic_wb_done: got %b want 1", wb_done); end
        total++; if (ofm_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drained: got %b want 0", ofm_valid); end
        tick();
        total++; if (wb_done !== 1'b0)   begin bad++; $display("[TB] FAIL basic_wb_pulse: got %b want 0", wb_done); end
    endtask

    task automatic test_relu;
        $display("[TB] relu");
        do_start(5'd4, 1'b1, 12'd1);
        load_basic_sums();
        for (int i = 0; i < COL; i++) sum[i] = test_sums[i];
        sum_valid = '1;
        tick();
        sum_valid = '0;
        tick();
`ifdef OFM_REQUANT_RELU_EN
        exp_data = 64'h00007f0000020100;
`else
        exp_data = 64'h00807fff00020100;
`endif
        total++; if (ofm_valid !== 1'b1)   begin bad++; $display("[TB] FAIL relu_valid: got %b want 1", ofm_valid); end
        total++; if (ofm_data !== exp_data) begin bad++; $display("[TB] FAIL relu_data: got %h want %h", ofm_data, exp_data); end
        ofm_ready = 1'b1;
        tick();
        ofm_ready = 1'b0;
    endtask

    task automatic test_staggered;
        $display("[TB] staggered lanes");
        do_start(5'd0, 1'b0, 12'd1);
        for (int i = 0; i < COL; i++) begin
            sum[i]    = i + 1;
            sum_valid = COL'(1) << i;
            tick();
            total++; if (busy !== 1'b1)      begin bad++; $display("[TB] FAIL stag_busy_%0d: got %b want 1", i, busy); end
            total++; if (ofm_valid !== 1'b0) begin bad++; $display("[TB] FAIL stag_early_%0d: got %b want 0", i, ofm_valid); end
        end
        sum_valid = '0;
        tick();
        total++; if (ofm_valid !== 1'b1) begin bad++; $display("[TB] FAIL stag_valid: got %b want 1", ofm_valid); end
        total++; if (ofm_data !== 64'h0807060504030201) begin bad++; $display("[TB] FAIL stag_data: got %h want %h", ofm_data, 64'h0807060504030201); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL stag_busy_hold: got %b want 1", busy); end
        ofm_ready = 1'b1;
        tick();
        total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL stag_busy_end: got %b want 0", busy); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("[TB] FAIL stag_overrun: got %b want 0", err_overrun); end
        tick();
        total++; if (ofm_valid !== 1'b0)   begin bad++; $display("[TB] FAIL stag_one_word: got %b want 0", ofm_valid); end
        ofm_ready = 1'b0;
    endtask

    task automatic test_overrun;
        $display("[TB] overrun");
        do_start(5'd0, 1'b0, 12'd1);
        sum[3] = 32'sd10;
        sum_valid = 8'b0000_1000;
        tick();
        sum[3] = 32'sd20;
        tick();
        for (int i = 0; i < COL; i++) if (i != 3) sum[i] = 32'h10 + i;
        sum_valid = 8'b1111_0111;
        tick();
        sum_valid = '0;
        total++; if (err_overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag: got %b want 1", err_overrun); end
        tick();
        total++; if (ofm_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_valid: got %b want 1", ofm_valid); end
        total++; if (ofm_data !== 64'h1716151414121110) begin bad++; $display("[TB] FAIL ovr_data: got %h want %h", ofm_data, 64'h1716151414121110); end
        ofm_ready = 1'b1;
        tick();
        ofm_ready = 1'b0;
        total++; if (err_overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky: got %b want 1", err_overrun); end
        do_start(5'd0, 1'b0, 12'd1);
        total++; if (err_overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear: got %b want 0", err_overrun); end
    endtask

    task automatic test_backpressure;
        $display("[TB] backpressure");
        ofm_ready = 1'b0;
        do_start(5'd0, 1'b0, 12'd6);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < COL; i++) sum[i] = k;
            sum_valid = '1;
            tick();
        end
        sum_valid = '0;
        tick();
        total++; if (err_fifo_ovf !== 1'b1) begin bad++; $display("[TB] FAIL bp_ovf: got %b want 1", err_fifo_ovf); end
        total++; if (ofm_data !== 64'h0101010101010101) begin bad++; $display("[TB] FAIL bp_head: got %h want %h", ofm_data, 64'h0101010101010101); end
        tick();
        tick();
        total++; if (ofm_data !== 64'h0101010101010101) begin bad++; $display("[TB] FAIL bp_stable: got %h want %h", ofm_data, 64'h0101010101010101); end
        ofm_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            lane_val = 8'(k);
            exp_data = {8{lane_val}};
            total++; if (ofm_valid !== 1'b1)   begin bad++; $display("[TB] FAIL bp_drain_valid_%0d: got %b want 1", k, ofm_valid); end
            total++; if (ofm_data !== exp_data) begin bad++; $display("[TB] FAIL bp_drain_%0d: got %h want %h", k, ofm_data, exp_data); end
            total++; if (ofm_last !== 1'b0)    begin bad++; $display("[TB] FAIL bp_drain_last_%0d: got %b want 0", k, ofm_last); end
            tick();
        end
        total++; if (ofm_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty: got %b want 0", ofm_valid); end
        strobe_all(32'sd6);
        tick();
        total++; if (ofm_data !== 64'h0606060606060606) begin bad++; $display("[TB] FAIL bp_sixth: got %h want %h", ofm_data, 64'h0606060606060606); end
        total++; if (ofm_last !== 1'b1) begin bad++; $display("[TB] FAIL bp_sixth_last: got %b want 1", ofm_last); end
        tick();
        total++; if (wb_done !== 1'b1) begin bad++; $display("[TB] FAIL bp_wb_done: got %b want 1", wb_done); end
        ofm_ready = 1'b0;
    endtask

    task automatic test_wrap_restart;
        $display("[TB] wrap and restart");
        do_start(5'd0, 1'b0, 12'd3);
        ofm_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            strobe_all(n);
            tick();
            lane_val = 8'(n);
            exp_data = {8{lane_val}};
            total++; if (ofm_data !== exp_data) begin bad++; $display("[TB] FAIL wrap_data_%0d: got %h want %h", n, ofm_data, exp_data); end
            total++; if (ofm_last !== (n % 3 == 0)) begin bad++; $display("[TB] FAIL wrap_last_%0d: got %b want %b", n, ofm_last, (n % 3 == 0)); end
            tick();
        end
        ofm_ready = 1'b0;
        strobe_all(32'sd7);
        strobe_all(32'sd8);
        tick();
        total++; if (ofm_valid !== 1'b1) begin bad++; $display("[TB] FAIL restart_pending: got %b want 1", ofm_valid); end
        do_start(5'd0, 1'b0, 12'd3);
        total++; if (ofm_valid !== 1'b0) begin bad++; $display("[TB] FAIL restart_flush: got %b want 0", ofm_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL restart_busy: got %b want 0", busy); end
        ofm_ready = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            strobe_all(32'sd9);
            tick();
            total++; if (ofm_last !== (n == 3)) begin bad++; $display("[TB] FAIL restart_last_%0d: got %b want %b", n, ofm_last, (n == 3)); end
            tick();
        end
        ofm_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start_conv = 1'b0;
        cfg_shift  = '0;
        cfg_relu   = 1'b0;
        cfg_words  = '0;
        sum_valid  = '0;
        ofm_ready  = 1'b0;
        for (int i = 0; i < COL; i++) sum[i] = '0;
        test_reset();
        test_basic_requant();
        test_relu();
        test_staggered();
        test_overrun();
        test_backpressure();
        test_wrap_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
